// File: rtl/systolic_output_deskew_if.sv
// Row stream from the deskew block to its consumer: one aligned N x DW row per beat.
// The master drives data/valid. The slave drives ready.
interface systolic_output_deskew_if #(
  parameter int unsigned N  = 16,
  parameter int unsigned DW = 32
) ();
  logic [N-1:0][DW-1:0] data;
  logic                 valid;
  logic                 ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/systolic_output_deskew.sv
// Realigns column-staggered systolic psums into rows and buffers them in a show-ahead FIFO.
// Optional DESKEW_RELU_EN clamps negative lane values to zero before the FIFO write.
module systolic_output_deskew #(
  parameter int unsigned N            = 16,
  parameter int unsigned DW           = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_MARGIN = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N-1:0][DW-1:0]            i_sys_output,
  input  logic [N-1:0]                    i_sys_valid_out,
  input  logic                            i_clr_flags,
  systolic_output_deskew_if.master        o_out,
  output logic                            o_almost_full,
  output logic                            o_overflow,
  output logic                            o_align_err,
  output logic [15:0]                     o_row_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] AfThresh = (AW + 1)'(DEPTH - AFULL_MARGIN);
  localparam logic [AW:0] FullCnt  = (AW + 1)'(DEPTH);

  typedef logic [N-1:0][DW-1:0] row_t;

  row_t         w_al_data;
  logic [N-1:0] w_al_valid;

  // Lane j is delayed by N-1-j cycles so every lane lines up with lane N-1.
  for (genvar j = 0; j < N; j++) begin : g_lane
    if (j == N - 1) begin : g_pass
      assign w_al_data[j]  = i_sys_output[j];
      assign w_al_valid[j] = i_sys_valid_out[j];
    end else begin : g_dly
      localparam int unsigned D = N - 1 - j;
      logic [DW-1:0] r_d [D];
      logic [D-1:0]  r_v;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < int'(D); k++) r_d[k] <= '0;
          r_v <= '0;
        end else begin
          r_d[0] <= i_sys_output[j];
          r_v[0] <= i_sys_valid_out[j];
          for (int k = 1; k < int'(D); k++) begin
            r_d[k] <= r_d[k-1];
            r_v[k] <= r_v[k-1];
          end
        end
      end

      assign w_al_data[j]  = r_d[D-1];
      assign w_al_valid[j] = r_v[D-1];
    end
  end

  logic w_align_mis;
  assign w_align_mis = (w_al_valid != {N{w_al_valid[N-1]}});

  row_t            r_stg_data;
  logic            r_stg_valid;
  row_t            w_wr_data;
  row_t            r_mem [DEPTH];
  row_t            r_last;
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;

  always_comb begin
    w_wr_data = r_stg_data;
`ifdef DESKEW_RELU_EN
    for (int j = 0; j < int'(N); j++) begin
      if (r_stg_data[j][DW-1]) w_wr_data[j] = '0;
    end
`endif
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FullCnt);
  assign w_pop   = !w_empty && o_out.ready;
  // A full FIFO still accepts a row when the head leaves on the same edge.
  assign w_push  = r_stg_valid && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stg_data    <= '0;
      r_stg_valid   <= 1'b0;
      r_last        <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      o_almost_full <= 1'b0;
      o_overflow    <= 1'b0;
      o_align_err   <= 1'b0;
      o_row_count   <= '0;
    end else begin
      r_stg_data    <= w_al_data;
      r_stg_valid   <= w_al_valid[N-1];
      o_almost_full <= (r_count >= AfThresh);
      o_align_err   <= w_align_mis || (o_align_err && !i_clr_flags);
      o_overflow    <= (r_stg_valid && !w_push) || (o_overflow && !i_clr_flags);
      if (w_push) begin
        r_wptr      <= r_wptr + 1'b1;
        o_row_count <= o_row_count + 16'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_last <= r_mem[r_rptr];
      end
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  assign o_out.valid = !w_empty;
  assign o_out.data  = w_empty ? r_last : r_mem[r_rptr];

endmodule
